// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
//   XLEN       : datapath width
//   REG_ZERO   : architectural zero register (writes to it are discarded)
//   wb_entry_t : one pending register-file write {rd, data}
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_bypass_match.sv
// Bypass lookup over the write-back queue storage.
// Searches the occupied entries (head .. head+count-1) for the newest one whose
// destination matches the query register. Register 0 never matches.
//   entries_i : queue storage (circular buffer)
//   head_i    : index of the oldest occupied entry
//   count_i   : number of occupied entries
//   q_reg_i   : queried register
//   hit_o     : a matching pending entry exists
//   data_o    : data of the newest matching entry, 0 on miss
module wb_bypass_match
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  wb_entry_t          entries_i [DEPTH],
  input  logic [PW-1:0]      head_i,
  input  logic [CW-1:0]      count_i,
  input  logic [4:0]         q_reg_i,
  output logic               hit_o,
  output logic [XLEN-1:0]    data_o
);

  // Per-age match flags: offset 0 is the oldest entry (the head).
  logic [DEPTH-1:0]    match;
  logic [XLEN-1:0]     data_at [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [PW-1:0] idx;
      // Pointer arithmetic wraps naturally because DEPTH is a power of two.
      assign idx         = head_i + PW'(gi);
      assign match[gi]   = (CW'(gi) < count_i) &&
                           (q_reg_i != REG_ZERO) &&
                           (entries_i[idx].rd == q_reg_i);
      assign data_at[gi] = entries_i[idx].data;
    end
  endgenerate

  // Later (younger) matches overwrite earlier ones, so the newest entry wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        hit_o  = 1'b1;
        data_o = data_at[k];
      end
    end
  end

endmodule

// File: rtl/mips_wb_queue.sv
// Write-back queue: merges ALU and load results onto the single register-file
// write port, buffering up to DEPTH pending writes, and offers a two-port
// bypass lookup of queued values.
//   clk, rst            : clock, synchronous active-high reset
//   alu_valid/reg/data  : ALU producer, alu_ready back-pressure
//   mem_valid/reg/data  : load producer, mem_ready back-pressure
//   regWrite/W_reg/W_data : register-file write port (combinational from head)
//   q_reg1/2 -> q_hit1/2, q_data1/2 : bypass lookups
//   count, empty, full  : occupancy status
module mips_wb_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_reg,
  input  logic [XLEN-1:0]            alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [4:0]                 mem_reg,
  input  logic [XLEN-1:0]            mem_data,
  output logic                       mem_ready,
  output logic                       regWrite,
  output logic [4:0]                 W_reg,
  output logic [XLEN-1:0]            W_data,
  input  logic [4:0]                 q_reg1,
  input  logic [4:0]                 q_reg2,
  output logic                       q_hit1,
  output logic                       q_hit2,
  output logic [XLEN-1:0]            q_data1,
  output logic [XLEN-1:0]            q_data2,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] ALU_LIMIT = CW'(DEPTH - 1);
  localparam logic [CW-1:0] MEM_LIMIT = CW'(DEPTH - 2);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  wb_entry_t     entries_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          alu_push, mem_push, pop;
  logic [PW-1:0] mem_slot;
  wb_entry_t     head_entry;

  // Ready looks only at registered occupancy. The load port keeps one extra
  // slot in reserve so a simultaneous double push can never overflow, even
  // though the same-cycle drain is not credited.
  assign alu_ready = (count_q <= ALU_LIMIT);
  assign mem_ready = (count_q <= MEM_LIMIT);

  // Register-0 transfers are accepted (handshake completes) but not stored.
  assign alu_push = alu_valid && alu_ready && (alu_reg != REG_ZERO);
  assign mem_push = mem_valid && mem_ready && (mem_reg != REG_ZERO);
  assign pop      = (count_q != '0);

  // ALU is older than mem in a double push, so mem lands one slot later.
  assign mem_slot = tail_q + PW'(alu_push);

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(alu_push) + PW'(mem_push);
    count_d = count_q + CW'(alu_push) + CW'(mem_push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (alu_push) entries_q[tail_q]   <= '{rd: alu_reg, data: alu_data};
      if (mem_push) entries_q[mem_slot] <= '{rd: mem_reg, data: mem_data};
    end
  end

  // The register file always accepts, so the head drains every non-empty cycle.
  assign head_entry = entries_q[head_q];
  assign regWrite   = pop;
  assign W_reg      = pop ? head_entry.rd   : 5'd0;
  assign W_data     = pop ? head_entry.data : '0;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  wb_bypass_match #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_bypass1 (
    .entries_i (entries_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .q_reg_i   (q_reg1),
    .hit_o     (q_hit1),
    .data_o    (q_data1)
  );

  wb_bypass_match #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_bypass2 (
    .entries_i (entries_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .q_reg_i   (q_reg2),
    .hit_o     (q_hit2),
    .data_o    (q_data2)
  );

endmodule

// File: tb/tb_mips_wb_queue.sv
module tb_mips_wb_queue;

  logic        clk;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_reg, mem_reg;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic        regWrite;
  logic [4:0]  W_reg;
  logic [31:0] W_data;
  logic [4:0]  q_reg1, q_reg2;
  logic        q_hit1, q_hit2;
  logic [31:0] q_data1, q_data2;
  logic [2:0]  count;
  logic        empty, full;

  int n_checks = 0;
  int n_fails  = 0;

  mips_wb_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_reg   (alu_reg),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_reg   (mem_reg),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .regWrite  (regWrite),
    .W_reg     (W_reg),
    .W_data    (W_data),
    .q_reg1    (q_reg1),
    .q_reg2    (q_reg2),
    .q_hit1    (q_hit1),
    .q_hit2    (q_hit2),
    .q_data1   (q_data1),
    .q_data2   (q_data2),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, act);
    end
  endtask

  // Advance one edge; inputs are changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Burst stimulus: both producers valid for four cycles.
  logic [4:0] b_alu_reg [4] = '{5'd10, 5'd12, 5'd14, 5'd16};
  logic [4:0] b_mem_reg [4] = '{5'd11, 5'd13, 5'd15, 5'd17};
  logic       b_alu_rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  logic       b_mem_rdy [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [2:0] b_cnt     [4] = '{3'd0, 3'd2, 3'd3, 3'd3};
  // W_reg seen during each burst cycle, then during the drain cycles.
  logic [4:0] b_wreg    [4] = '{5'd0, 5'd10, 5'd11, 5'd12};
  logic [4:0] d_wreg    [3] = '{5'd13, 5'd14, 5'd16};

  initial begin
    rst = 1'b1;
    q_reg1 = 5'd5;
    q_reg2 = 5'd0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check_eq("rst_count",    32'(count),     32'd0);
    check_eq("rst_empty",    32'(empty),     32'd1);
    check_eq("rst_full",     32'(full),      32'd0);
    check_eq("rst_regWrite", 32'(regWrite),  32'd0);
    check_eq("rst_W_reg",    32'(W_reg),     32'd0);
    check_eq("rst_W_data",   W_data,         32'd0);
    check_eq("rst_alu_rdy",  32'(alu_ready), 32'd1);
    check_eq("rst_mem_rdy",  32'(mem_ready), 32'd1);
    check_eq("rst_q_hit1",   32'(q_hit1),    32'd0);
    check_eq("rst_q_data1",  q_data1,        32'd0);

    // Single ALU push: visible on the write port in the next cycle
    tick();
    drive(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'h0);
    tick();
    idle();
    #1;
    check_eq("p1_regWrite", 32'(regWrite), 32'd1);
    check_eq("p1_W_reg",    32'(W_reg),    32'd5);
    check_eq("p1_W_data",   W_data,        32'h0000_1234);
    check_eq("p1_count",    32'(count),    32'd1);
    check_eq("p1_q_hit1",   32'(q_hit1),   32'd1);
    check_eq("p1_q_data1",  q_data1,       32'h0000_1234);
    tick();
    check_eq("p1_empty",    32'(empty),    32'd1);
    check_eq("p1_regWr0",   32'(regWrite), 32'd0);

    // Simultaneous ALU + mem: ALU retires first
    drive(1'b1, 5'd3, 32'h0000_000A, 1'b1, 5'd4, 32'h0000_000B);
    tick();
    idle();
    #1;
    check_eq("dp_count",  32'(count), 32'd2);
    check_eq("dp_W_reg0", 32'(W_reg), 32'd3);
    check_eq("dp_W_dat0", W_data,     32'h0000_000A);
    tick();
    check_eq("dp_W_reg1", 32'(W_reg), 32'd4);
    check_eq("dp_W_dat1", W_data,     32'h0000_000B);
    check_eq("dp_count1", 32'(count), 32'd1);
    tick();
    check_eq("dp_empty",  32'(empty), 32'd1);

    // Register 0 push: accepted, never stored
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    #1;
    check_eq("r0_alu_rdy", 32'(alu_ready), 32'd1);
    tick();
    idle();
    #1;
    check_eq("r0_count",    32'(count),    32'd0);
    check_eq("r0_regWrite", 32'(regWrite), 32'd0);
    tick();
    check_eq("r0_regWr2",   32'(regWrite), 32'd0);

    // Sustained double pushes: back-pressure, ordering and pointer wrap
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, b_alu_reg[c], 32'hD000 + 32'(b_alu_reg[c]),
            1'b1, b_mem_reg[c], 32'hD000 + 32'(b_mem_reg[c]));
      #1;
      check_eq($sformatf("bu%0d_alu_rdy", c), 32'(alu_ready), 32'(b_alu_rdy[c]));
      check_eq($sformatf("bu%0d_mem_rdy", c), 32'(mem_ready), 32'(b_mem_rdy[c]));
      check_eq($sformatf("bu%0d_count", c),   32'(count),     32'(b_cnt[c]));
      check_eq($sformatf("bu%0d_W_reg", c),   32'(W_reg),     32'(b_wreg[c]));
      check_eq($sformatf("bu%0d_full", c),    32'(full),      32'd0);
      tick();
    end
    idle();
    #1;
    for (int c = 0; c < 3; c++) begin
      check_eq($sformatf("dr%0d_W_reg", c),  32'(W_reg), 32'(d_wreg[c]));
      check_eq($sformatf("dr%0d_W_data", c), W_data,     32'hD000 + 32'(d_wreg[c]));
      tick();
    end
    check_eq("dr_empty",    32'(empty),    32'd1);
    check_eq("dr_regWrite", 32'(regWrite), 32'd0);

    // Bypass: two pending r7 writes behind an older head entry
    drive(1'b1, 5'd1, 32'h0000_0011, 1'b1, 5'd7, 32'h0000_0001);
    tick();
    drive(1'b1, 5'd7, 32'h0000_0002, 1'b1, 5'd8, 32'h0000_0088);
    q_reg1 = 5'd7;
    q_reg2 = 5'd9;
    #1;
    // The r7=0x2 being pushed this cycle is not yet searchable.
    check_eq("by_pre_hit1",  32'(q_hit1), 32'd1);
    check_eq("by_pre_data1", q_data1,     32'h0000_0001);
    tick();
    idle();
    #1;
    check_eq("by_count",  32'(count),   32'd3);
    check_eq("by_W_reg",  32'(W_reg),   32'd7);
    check_eq("by_hit1",   32'(q_hit1),  32'd1);
    check_eq("by_data1",  q_data1,      32'h0000_0002);
    check_eq("by_hit2",   32'(q_hit2),  32'd0);
    check_eq("by_data2",  q_data2,      32'h0000_0000);
    q_reg2 = 5'd8;
    #1;
    check_eq("by_hit2b",  32'(q_hit2),  32'd1);
    check_eq("by_data2b", q_data2,      32'h0000_0088);
    q_reg2 = 5'd0;
    #1;
    check_eq("by_hit_r0", 32'(q_hit2),  32'd0);

    // Reset with three entries pending drops them all
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("mr_count",    32'(count),     32'd0);
    check_eq("mr_regWrite", 32'(regWrite),  32'd0);
    check_eq("mr_alu_rdy",  32'(alu_ready), 32'd1);
    check_eq("mr_mem_rdy",  32'(mem_ready), 32'd1);
    check_eq("mr_hit1",     32'(q_hit1),    32'd0);
    drive(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'h0);
    tick();
    idle();
    #1;
    check_eq("mr_W_reg",  32'(W_reg),    32'd9);
    check_eq("mr_W_data", W_data,        32'h0000_0099);
    check_eq("mr_regWr",  32'(regWrite), 32'd1);
    tick();
    check_eq("mr_empty",  32'(empty),    32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
